// File: rtl/mem_ctrl_pkg.sv
// Shared types, funct3 codes and request-legality helpers for the memory
// access controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only have signed-width codes; loads also have the unsigned ones.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    if (we) begin
      return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end
    return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane logic: load extract/extend and store merge for
// sub-word accesses into a 32-bit word.
module mem_lane_fmt
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane and extend it according to funct3.
  always_comb begin
    byte_sel  = word[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? word[31:16] : word[15:0];
    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = word;
    endcase
  end

  // Replace the addressed lane of the old word; a full word store ignores it.
  always_comb begin
    store_word = word;
    case (funct3)
      F3_B: store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer in front of a word-addressed memory with async read
// and sync write. One request in flight; sub-word stores use read-modify-write.
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE. The response is a single-cycle resp_valid
// strobe with no ready, so the requester must take it in that cycle.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int BIT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0]  req_wdata,
  output logic                  resp_valid,
  output logic [BIT_WIDTH-1:0]  resp_rdata,
  output logic                  resp_fault,
  output logic [ADDR_WIDTH-1:0] mem_readAddr,
  output logic [ADDR_WIDTH-1:0] mem_writeAddr,
  output logic [BIT_WIDTH-1:0]  mem_writeData,
  output logic                  mem_writeEn,
  input  logic [BIT_WIDTH-1:0]  mem_readData,
  output logic [1:0]            dbg_state
);

  state_t                state_q, state_d;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BIT_WIDTH-1:0]  wdata_q;
  logic [BIT_WIDTH-1:0]  word_q;
  logic                  hs;
  logic                  fault_in;
  logic [BIT_WIDTH-1:0]  load_data;
  logic [BIT_WIDTH-1:0]  store_word;

  assign hs       = req_valid && req_ready;
  assign fault_in = !is_legal(req_we, req_funct3) ||
                    is_misaligned(req_funct3, req_addr[1:0]);

  // Load data comes straight from memory in RD; merges use the word captured there.
  mem_lane_fmt u_fmt (
    .word       (state_q == RD ? mem_readData : word_q),
    .addr_lo    (addr_q[1:0]),
    .funct3     (f3_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Next-state decode; req_ready is the IDLE indicator.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (fault_in)                           state_d = RESP;
          else if (req_we && req_funct3 == F3_W)  state_d = WR;
          else                                    state_d = RD;
        end
      end
      RD:      state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, request latches, read capture and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      word_q     <= '0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == RD) word_q <= mem_readData;
      resp_valid <= (state_d == RESP);
      resp_fault <= hs && fault_in;
      resp_rdata <= (state_q == RD && !we_q) ? load_data : '0;
    end
  end

  // Reset kills the write strobe in the same cycle so no partial write lands.
  assign mem_writeEn   = (state_q == WR) && !rst;
  assign mem_writeData = store_word;
  assign mem_readAddr  = addr_q;
  assign mem_writeAddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: word memory model, directed cases from the
// plan, then randomized requests checked against a byte-arithmetic model.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_readAddr, mem_writeAddr, mem_writeData, mem_readData;
  logic        mem_writeEn;
  logic [1:0]  dbg_state;

  logic [31:0] dmem [0:63];
  logic [31:0] ref_mem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  int          wr_cnt = 0;
  logic [31:0] last_wa = '0, last_wd = '0;
  int          cyc = 0;
  int          hs_q[$];
  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  mem_access_ctrl #(.ADDR_WIDTH(32), .BIT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .mem_readAddr(mem_readAddr),
    .mem_writeAddr(mem_writeAddr), .mem_writeData(mem_writeData),
    .mem_writeEn(mem_writeEn), .mem_readData(mem_readData),
    .dbg_state(dbg_state)
  );

  // Clock and memory model
  always #5 clk = ~clk;

  assign mem_readData = dmem[mem_readAddr[7:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready && !rst) hs_q.push_back(cyc);
    if (pl_en) begin
      dmem[pl_idx] <= pl_val;
    end else if (mem_writeEn) begin
      dmem[mem_writeAddr[7:2]] <= mem_writeData;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= mem_writeAddr;
      last_wd <= mem_writeData;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: plain byte arithmetic on whole words
  function automatic logic ref_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 <= 3'd2;
    return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic int ref_size(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [7:0] a,
                                           input logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] wd,
                                            input logic [7:0] a, input logic [2:0] f3);
    logic [31:0] mask;
    if (f3 == 3'd2) return wd;
    mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << (8 * (a % 4));
    return (w & ~mask) | ((wd << (8 * (a % 4))) & mask);
  endfunction

  // Driver tasks
  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx[5:0]; pl_val = val;
    @(posedge clk);
    #1 pl_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                        input logic [31:0] wd, output logic [31:0] rdata,
                        output logic fault);
    logic        exp_fault;
    int          exp_lat, lat, wr0, idx;
    logic [31:0] exp_word;
    idx       = addr / 4;
    exp_fault = !ref_legal(we, f3) || ((addr % ref_size(f3)) != 0);
    exp_lat   = exp_fault ? 1 : (!we ? 2 : (f3 == 3'd2 ? 2 : 3));
    exp_q.push_back((exp_fault || we) ? 32'h0 : ref_load(ref_mem[idx], addr, f3));
    exp_word  = (we && !exp_fault) ? ref_store(ref_mem[idx], wd, addr, f3) : ref_mem[idx];
    wr0 = wr_cnt;
    @(negedge clk);
    chk("resp_pulse", {31'b0, resp_valid}, 32'd0);
    chk("ready_idle", {31'b0, req_ready}, 32'd1);
    req_we = we; req_funct3 = f3; req_addr = {24'h0, addr}; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    rdata = resp_rdata;
    fault = resp_fault;
    chk("latency", lat, exp_lat);
    chk("fault", {31'b0, resp_fault}, {31'b0, exp_fault});
    chk("rdata", resp_rdata, exp_q.pop_front());
    chk("wr_count", wr_cnt - wr0, (we && !exp_fault) ? 32'd1 : 32'd0);
    if (we && !exp_fault) begin
      chk("waddr", last_wa, {24'h0, addr & 8'hFC});
      chk("wdata", last_wd, exp_word);
    end
    ref_mem[idx] = exp_word;
  endtask

  initial begin
    logic [31:0] rd, lw_data;
    logic        flt;
    int          wr0, h0, low_cnt, sw_resp;
    logic        got_lw;

    for (int i = 0; i < 64; i++) begin
      dmem[i]    = 32'h0;
      ref_mem[i] = 32'h0;
    end

    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_fault", {31'b0, resp_fault}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_wen", {31'b0, mem_writeEn}, 32'd0);
    chk("rst_state", {30'b0, dbg_state}, {30'b0, IDLE});

    // Directed loads
    preload(4, 32'h8899AABB);
    do_req(1'b0, F3_B,  8'h11, 32'h0, rd, flt); chk("lb_11",  rd, 32'hFFFFFFAA);
    do_req(1'b0, F3_BU, 8'h13, 32'h0, rd, flt); chk("lbu_13", rd, 32'h00000088);
    do_req(1'b0, F3_H,  8'h10, 32'h0, rd, flt); chk("lh_10",  rd, 32'hFFFFAABB);
    do_req(1'b0, F3_HU, 8'h12, 32'h0, rd, flt); chk("lhu_12", rd, 32'h00008899);
    do_req(1'b0, F3_W,  8'h10, 32'h0, rd, flt); chk("lw_10",  rd, 32'h8899AABB);

    // Faults leave memory alone
    do_req(1'b1, F3_H,  8'h11, 32'h1234, rd, flt); chk("sh_mis_fault", {31'b0, flt}, 32'd1);
    do_req(1'b0, F3_W,  8'h12, 32'h0,    rd, flt); chk("lw_mis_fault", {31'b0, flt}, 32'd1);
    do_req(1'b1, F3_BU, 8'h10, 32'hFF,   rd, flt); chk("st_f3_fault",  {31'b0, flt}, 32'd1);
    chk("fault_mem", dmem[4], 32'h8899AABB);

    // Reset in the WR cycle of a word store
    wr0 = wr_cnt;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h10; req_wdata = 32'h0;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("wr_state", {30'b0, dbg_state}, {30'b0, WR});
    rst = 1'b1;
    #1 chk("rst_kills_wen", {31'b0, mem_writeEn}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("post_rst_resp", {31'b0, resp_valid}, 32'd0);
    chk("post_rst_nowrite", wr_cnt - wr0, 32'd0);
    chk("post_rst_word", dmem[4], 32'h8899AABB);

    // Sub-word stores
    do_req(1'b1, F3_B, 8'h12, 32'h123456CC, rd, flt);
    chk("sb_wdata", last_wd, 32'h88CCAABB);
    chk("sb_waddr", last_wa, 32'h10);
    do_req(1'b1, F3_H, 8'h10, 32'h0000DEAD, rd, flt);
    chk("sh_word", dmem[4], 32'h88CCDEAD);

    // Back-to-back: SW then LW with req_valid held high
    @(negedge clk);
    req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    h0 = hs_q.size(); low_cnt = 0; sw_resp = 0; got_lw = 1'b0; lw_data = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (hs_q.size() == h0 + 1) begin
        if (!req_ready) low_cnt++;
        if (resp_valid) sw_resp++;
        req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h20;
      end
      if (hs_q.size() >= h0 + 2) begin
        req_valid = 1'b0;
        if (resp_valid) begin
          got_lw = 1'b1; lw_data = resp_rdata;
          break;
        end
      end
    end
    req_valid = 1'b0;
    ref_mem[8] = 32'hCAFEF00D;
    if (hs_q.size() >= h0 + 2) chk("b2b_spacing", hs_q[h0 + 1] - hs_q[h0], 32'd3);
    else                       chk("b2b_hs_count", hs_q.size() - h0, 32'd2);
    chk("b2b_ready_low", low_cnt, 32'd2);
    chk("b2b_sw_resp", sw_resp, 32'd1);
    chk("b2b_lw_seen", {31'b0, got_lw}, 32'd1);
    chk("b2b_lw_data", lw_data, 32'hCAFEF00D);

    // Randomized requests over a randomly filled memory
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    for (int i = 0; i < 250; i++) begin
      logic [7:0]  a;
      logic [2:0]  f3;
      logic        we;
      we = $urandom_range(0, 1) == 1;
      f3 = 3'($urandom_range(0, 7));
      a  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~8'(ref_size(f3) - 1);
      do_req(we, f3, a, $urandom, rd, flt);
    end
    for (int i = 0; i < 64; i++) chk("final_mem", dmem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
